hamming_link_ctrl: RTL and testbench

HAMMING_LINK_CTRL -- requirements
Module: hamming_link_ctrl

---
 rtl/hamming_link_ctrl_pkg.sv | 27 ++
 rtl/hamming_link_ctrl_codec.sv | 37 +++
 rtl/hamming_link_ctrl.sv | 107 ++++++++++
 tb/tb_hamming_link_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_link_ctrl_pkg.sv
// rtl/hamming_link_ctrl_pkg.sv - shared FSM encodings and Hamming(7,4) bit-position constants
package hamming_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ENC  = 3'd1,
        ST_CHAN = 3'd2,
        ST_DEC  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    localparam logic [6:0] WALK_RST = 7'b0000001;

    // Codeword bit index i carries Hamming position i+1
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P3_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    localparam logic [6:0] S1_MASK = 7'b1010101;
    localparam logic [6:0] S2_MASK = 7'b1100110;
    localparam logic [6:0] S3_MASK = 7'b1111000;

endpackage

// File: rtl/hamming_link_ctrl_codec.sv
// rtl/hamming_link_ctrl_codec.sv - combinational Hamming(7,4) encoder and single-error-correcting decoder
module hamming74_codec
    import hamming_link_ctrl_pkg::*;
(
    input  logic [3:0] data,
    input  logic [6:0] code,
    output logic [6:0] enc_word,
    output logic [3:0] dec_data,
    output logic       syn_nz
);

    logic [2:0] syn;
    logic [6:0] fixed;

    always_comb begin
        enc_word         = '0;
        enc_word[D0_POS] = data[0];
        enc_word[D1_POS] = data[1];
        enc_word[D2_POS] = data[2];
        enc_word[D3_POS] = data[3];
        enc_word[P1_POS] = data[0] ^ data[1] ^ data[3];
        enc_word[P2_POS] = data[0] ^ data[2] ^ data[3];
        enc_word[P3_POS] = data[1] ^ data[2] ^ data[3];
    end

    always_comb begin
        syn   = {^(code & S3_MASK), ^(code & S2_MASK), ^(code & S1_MASK)};
        fixed = code;
        // Syndrome value is the 1-based position of the flipped bit
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~code[syn - 3'd1];
        end
        dec_data = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
        syn_nz   = (syn != 3'd0);
    end

endmodule

// File: rtl/hamming_link_ctrl.sv
// rtl/hamming_link_ctrl.sv - nibble link: encode, inject channel errors, decode, count mismatches
module hamming_link_ctrl
    import hamming_link_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       d_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       err_mask,
    input  logic             err_auto,
    output logic [3:0]       d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       chan_word,
    output logic             corrected,
    output logic             mismatch,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t     state;
    logic [3:0] d_reg;
    logic [6:0] pat_reg;
    logic [6:0] code_reg;
    logic [6:0] walk;
    logic [6:0] enc_word;
    logic [3:0] dec_data;
    logic       syn_nz;

    // One codec: encoder half is used in ENC, decoder half in DEC
    hamming74_codec u_codec (
        .data     (d_reg),
        .code     (chan_word),
        .enc_word (enc_word),
        .dec_data (dec_data),
        .syn_nz   (syn_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d_reg     <= '0;
            pat_reg   <= '0;
            code_reg  <= '0;
            walk      <= WALK_RST;
            chan_word <= '0;
            d_out     <= '0;
            corrected <= 1'b0;
            mismatch  <= 1'b0;
            word_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        d_reg    <= d_in;
                        pat_reg  <= err_auto ? walk : err_mask;
                        if (err_auto) begin
                            walk <= {walk[5:0], walk[6]};
                        end
                        in_ready <= 1'b0;
                        state    <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    code_reg <= enc_word;
                    state    <= ST_CHAN;
                end
                ST_CHAN: begin
                    chan_word <= code_reg ^ pat_reg;
                    state     <= ST_DEC;
                end
                ST_DEC: begin
                    d_out     <= dec_data;
                    corrected <= syn_nz;
                    mismatch  <= (dec_data != d_reg);
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_valid && out_ready) begin
                        if (word_cnt != '1) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                        if (mismatch && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// tb/tb_hamming_link_ctrl.sv - directed table-driven bench for hamming_link_ctrl
module tb_hamming_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d_in;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] err_mask;
    logic       err_auto;
    logic [3:0] d_out;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] chan_word;
    logic       corrected;
    logic       mismatch;
    logic [7:0] word_cnt;
    logic [7:0] err_cnt;

    logic [3:0] d_in2;
    logic       in_valid2;
    logic       in_ready2;
    logic [6:0] err_mask2;
    logic       err_auto2;
    logic [3:0] d_out2;
    logic       out_valid2;
    logic       out_ready2;
    logic [6:0] chan_word2;
    logic       corrected2;
    logic       mismatch2;
    logic [1:0] word_cnt2;
    logic [1:0] err_cnt2;

    always #5 clk = ~clk;

    hamming_link_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
        .err_mask(err_mask), .err_auto(err_auto), .d_out(d_out), .out_valid(out_valid),
        .out_ready(out_ready), .chan_word(chan_word), .corrected(corrected),
        .mismatch(mismatch), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    hamming_link_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in2), .in_valid(in_valid2), .in_ready(in_ready2),
        .err_mask(err_mask2), .err_auto(err_auto2), .d_out(d_out2), .out_valid(out_valid2),
        .out_ready(out_ready2), .chan_word(chan_word2), .corrected(corrected2),
        .mismatch(mismatch2), .word_cnt(word_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic [3:0] d;
        logic [6:0] mask;
        logic [6:0] chan;
        logic [3:0] dout;
        logic       corr;
        logic       mis;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad = 0;
    int   exp_words = 0;
    int   exp_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [6:0] mask, input logic auto,
                        input logic [6:0] e_chan, input logic [3:0] e_dout,
                        input logic e_corr, input logic e_mis, input int hold, input string tag);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        out_ready = (hold == 0);
        d_in      = d;
        err_mask  = mask;
        err_auto  = auto;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d_in     = ~d;
        err_mask = ~mask;
        err_auto = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 12);
        chk({tag, " latency"}, n, 4);
        chk({tag, " chan_word"}, chan_word, e_chan);
        chk({tag, " d_out"}, d_out, e_dout);
        chk({tag, " corrected"}, corrected, e_corr);
        chk({tag, " mismatch"}, mismatch, e_mis);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                d_in     = 4'b0000;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, " hold out_valid"}, out_valid, 1);
            chk({tag, " hold in_ready"}, in_ready, 0);
            chk({tag, " hold chan_word"}, chan_word, e_chan);
            chk({tag, " hold d_out"}, d_out, e_dout);
            chk({tag, " hold flags"}, {corrected, mismatch}, {e_corr, e_mis});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_words++;
        if (e_mis) exp_errs++;
        chk({tag, " word_cnt"}, word_cnt, exp_words);
        chk({tag, " err_cnt"}, err_cnt, exp_errs);
        chk({tag, " out_valid low"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int cyc;
        int seen;
        logic [6:0] pat;

        vecs[0] = '{4'b1011, 7'b0000000, 7'b1010101, 4'b1011, 1'b0, 1'b0};
        vecs[1] = '{4'b1011, 7'b0000100, 7'b1010001, 4'b1011, 1'b1, 1'b0};
        vecs[2] = '{4'b1011, 7'b0000011, 7'b1010110, 4'b1010, 1'b1, 1'b1};
        vecs[3] = '{4'b0000, 7'b0000000, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[4] = '{4'b1111, 7'b1000000, 7'b0111111, 4'b1111, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 7'b0000011, 7'b0000011, 4'b0001, 1'b1, 1'b1};

        rst_n = 1'b0; d_in = '0; in_valid = 1'b0; err_mask = '0; err_auto = 1'b0; out_ready = 1'b1;
        d_in2 = '0; in_valid2 = 1'b0; err_mask2 = 7'b0000011; err_auto2 = 1'b0; out_ready2 = 1'b1;
        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset outputs", {d_out, chan_word, corrected, mismatch}, 0);
        chk("reset counters", {word_cnt, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].mask, 1'b0, vecs[i].chan, vecs[i].dout,
                 vecs[i].corr, vecs[i].mis, 0, $sformatf("vec%0d", i));
        end

        // Walking-one pattern over eight words, wrapping after bit 6
        pat = 7'b0000001;
        for (int i = 0; i < 8; i++) begin
            send(4'b0110, 7'b0000000, 1'b1, 7'b0110011 ^ pat, 4'b0110, 1'b1, 1'b0, 0,
                 $sformatf("walk%0d", i));
            pat = {pat[5:0], pat[6]};
        end

        send(4'b0110, 7'b0010000, 1'b0, 7'b0100011, 4'b0110, 1'b1, 1'b0, 6, "hold");
        send(4'b1011, 7'b0000000, 1'b0, 7'b1010101, 4'b1011, 1'b0, 1'b0, 0, "after_hold");

        // Reset while the word sits in CHAN
        @(negedge clk);
        d_in = 4'b1011; err_mask = 7'b0000011; err_auto = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst outputs", {d_out, chan_word, corrected, mismatch}, 0);
        chk("midrst counters", {word_cnt, err_cnt}, 0);
        chk("midrst out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst no output", seen, 0);
        chk("midrst counters hold", {word_cnt, err_cnt}, 0);
        exp_words = 0;
        exp_errs  = 0;
        send(4'b0110, 7'b0000000, 1'b1, 7'b0110010, 4'b0110, 1'b1, 1'b0, 0, "walk_after_rst");

        // Saturating 2-bit counters on the second instance
        @(negedge clk);
        in_valid2 = 1'b1;
        hs = 0;
        cyc = 0;
        while (hs < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid2 && out_ready2) begin
                hs++;
                if (hs == 3) chk("sat word_cnt after 2", word_cnt2, 2);
                if (hs == 4) chk("sat word_cnt after 3", word_cnt2, 3);
                if (hs == 5) in_valid2 = 1'b0;
            end
        end
        chk("sat handshakes", hs, 5);
        @(posedge clk);
        #1;
        chk("sat word_cnt", word_cnt2, 3);
        chk("sat err_cnt", err_cnt2, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
